mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the CPU's single memory port (mem_read/mem_write/mem_address/mem_wdata/mem_byte_enable/mem_rdata/mem_resp) between two requesters:
  - the instruction fetcher (read-only);
  - the load/store queue (read/write).
- Sits between the fetcher, the LSQ and the top-level memory pins of cpu.
- Latches the granted request, drives the port from registers and routes mem_resp/mem_rdata back to the granted requester.
- Handles a pipeline flush that kills an in-flight fetch.

Parameters:
- width, 32, data/address width.
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush; kills the pending or in-flight fetch.
- i_read  in  1  fetch request, held high until i_resp.
- i_addr  in  width  fetch address.
- i_rdata  out  width  fetch data, valid when i_resp=1.
- i_resp  out  1  fetch completion pulse.
- d_read  in  1  LSQ load request, held until d_resp.
- d_write  in  1  LSQ store request, held until d_resp.
- d_addr  in  width  LSQ address.
- d_wdata  in  width  store data.
- d_byte_enable  in  width/8  store byte mask.
- d_rdata  out  width  load data, valid when d_resp=1.
- d_resp  out  1  LSQ completion pulse.
- mem_resp  in  1  memory done.
- mem_rdata  in  width  memory read data.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_byte_enable  out  width/8  write byte mask.
- mem_address  out  width  memory address.
- mem_wdata  out  width  write data.

Behaviour:
- States: IDLE, IFETCH, DATA, IDROP.
- Reset (async, any state): state=IDLE; starve count=0; latched address/data/mask=0. Outputs: mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=0, i_resp=0, d_resp=0, i_rdata=0, d_rdata=0. Reset mid-transaction abandons it; no response is issued.
- Arbitration in IDLE, evaluated at the rising edge:
  - (d_read|d_write) -> DATA; latch d_addr, d_wdata, d_byte_enable and the op.
  - else i_read & ~flush -> IFETCH; latch i_addr.
  - else stay in IDLE.
  - Default priority is data over fetch.
- Latency: a request sampled in IDLE at edge N drives the mem strobe from cycle N+1. The strobe stays high until the cycle mem_resp=1.
- Strobe encoding:
  - IFETCH and IDROP: mem_read=1, mem_byte_enable=0.
  - DATA: mem_read=op_read, mem_write=op_write, mem_byte_enable=latched mask (4'hF on reads).
  - d_read and d_write both high: write wins.
- Completion in IFETCH/DATA: the cycle mem_resp=1, combinationally i_resp (or d_resp)=1 and i_rdata/d_rdata=mem_rdata; next state=IDLE.
  - One-cycle pulse only; minimum one IDLE cycle between grants.
  - The non-granted resp output is always 0.
- Flush:
  - In IDLE: blocks a fetch grant that cycle.
  - In IFETCH: -> IDROP; keeps mem_read high until mem_resp, then IDLE with i_resp held 0.
  - In the same cycle as mem_resp in IFETCH: i_resp suppressed, -> IDLE.
  - Data transactions are never killed by flush.
- Inputs are ignored outside IDLE; latched values hold stable for the whole transaction.
- mem_resp in IDLE is ignored.

Optional Feature:
- MEM_ARB_STARVE_GUARD_EN defined:
  - Counter increments on each DATA grant made while i_read=1, and clears on each IFETCH grant.
  - When count==STARVE_LIMIT and i_read & ~flush, IDLE grants IFETCH even if a data request is pending.
- Undefined: no counter; strict data priority; a continuous LSQ stream may starve fetch.

Test Plan:
- Single fetch: i_read=1, i_addr=0x60 -> mem_read=1, mem_address=0x60 next cycle; memory returns 0x00A00093 after 3 cycles -> i_resp pulse of 1 cycle with i_rdata=0x00A00093, then IDLE.
- Simultaneous requests: i_read=1 (0x64) and d_write=1 (0x1000, wdata 0xDEADBEEF, mask 4'b0011) at the same edge -> write issued first with mem_byte_enable=0011; after d_resp, fetch of 0x64 issued.
- Flush mid-fetch: fetch 0x80 granted, flush pulsed 1 cycle before mem_resp -> mem_read stays high until mem_resp, i_resp never asserts; a subsequent fetch of 0x200 completes normally.
- Async reset mid-DATA: rst asserted between clock edges while mem_write=1 -> all outputs 0 immediately; after release, a new d_read to 0x2000 completes with d_rdata=mem_rdata.
- Starvation (MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT=4): i_read held, LSQ issues 6 back-to-back loads -> grant order D,D,D,D,I,D,D. Without the macro -> D×6, then I.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, LSQ and memory-port signals around mem_arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_arbiter_if #(
    parameter int width = 32
);
    logic                 flush;
    logic                 i_read;
    logic [width-1:0]     i_addr;
    logic [width-1:0]     i_rdata;
    logic                 i_resp;
    logic                 d_read;
    logic                 d_write;
    logic [width-1:0]     d_addr;
    logic [width-1:0]     d_wdata;
    logic [width/8-1:0]   d_byte_enable;
    logic [width-1:0]     d_rdata;
    logic                 d_resp;
    logic                 mem_resp;
    logic [width-1:0]     mem_rdata;
    logic                 mem_read;
    logic                 mem_write;
    logic [width/8-1:0]   mem_byte_enable;
    logic [width-1:0]     mem_address;
    logic [width-1:0]     mem_wdata;

    modport slave (
        input  flush, i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_byte_enable,
               mem_resp, mem_rdata,
        output i_rdata, i_resp, d_rdata, d_resp,
               mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
    );

    modport master (
        output flush, i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_byte_enable,
               mem_resp, mem_rdata,
        input  i_rdata, i_resp, d_rdata, d_resp,
               mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between the instruction fetcher and the LSQ; data wins by default.
// Optional macro MEM_ARB_STARVE_GUARD_EN forces a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int width        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_arbiter_if.slave         bus,
    output logic [1:0]           state_o
);

    // Handshake: a requester holds its request until its one-cycle resp pulse;
    // memory holds nothing, the strobe stays high until the cycle mem_resp=1.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        DATA   = 2'd2,
        IDROP  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [width-1:0]     addr_q;
    logic [width-1:0]     wdata_q;
    logic [width/8-1:0]   mask_q;
    logic                 mem_read_q;
    logic                 mem_write_q;

    logic                 idle;
    logic                 d_req;
    logic                 i_ok;
    logic                 grant_d;
    logic                 grant_i;
    logic                 i_done;
    logic                 d_done;

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("mem_arbiter: STARVE_LIMIT must be at least 1");
    end

    assign idle  = (state_q == IDLE);
    assign d_req = bus.d_read | bus.d_write;
    assign i_ok  = bus.i_read & ~bus.flush;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_q, starve_d;
    logic          starved;

    assign starved = (starve_q == CW'(STARVE_LIMIT));
    assign grant_i = idle & i_ok & (~d_req | starved);
    assign grant_d = idle & d_req & ~grant_i;

    // Saturates at the limit so a flushed fetch cannot wrap the count.
    always_comb begin
        starve_d = starve_q;
        if (grant_i) begin
            starve_d = '0;
        end else if (grant_d && bus.i_read && !starved) begin
            starve_d = starve_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign grant_d = idle & d_req;
    assign grant_i = idle & i_ok & ~d_req;
`endif

    assign i_done = (state_q == IFETCH) & bus.mem_resp & ~bus.flush;
    assign d_done = (state_q == DATA) & bus.mem_resp;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = DATA;
                end else if (grant_i) begin
                    state_d = IFETCH;
                end
            end
            IFETCH: begin
                if (bus.mem_resp) begin
                    state_d = IDLE;
                end else if (bus.flush) begin
                    state_d = IDROP;
                end
            end
            DATA, IDROP: begin
                if (bus.mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fetches carry no byte mask; loads present a full-word mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_d) begin
                addr_q      <= bus.d_addr;
                wdata_q     <= bus.d_wdata;
                mask_q      <= bus.d_write ? bus.d_byte_enable : '1;
                mem_read_q  <= ~bus.d_write;
                mem_write_q <= bus.d_write;
            end else if (grant_i) begin
                addr_q      <= bus.i_addr;
                mask_q      <= '0;
                mem_read_q  <= 1'b1;
                mem_write_q <= 1'b0;
            end else if (!idle && bus.mem_resp) begin
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
            end
        end
    end

    assign bus.mem_read        = mem_read_q;
    assign bus.mem_write       = mem_write_q;
    assign bus.mem_address     = addr_q;
    assign bus.mem_wdata       = wdata_q;
    assign bus.mem_byte_enable = mask_q;

    assign bus.i_resp  = i_done;
    assign bus.d_resp  = d_done;
    assign bus.i_rdata = i_done ? bus.mem_rdata : '0;
    assign bus.d_rdata = d_done ? bus.mem_rdata : '0;

    assign state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner-case sequences and
// a grant/response scoreboard fed at stimulus time.
module tb_mem_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] state_o;

    mem_arbiter_if #(.width(32)) bus ();

    mem_arbiter #(.width(32), .STARVE_LIMIT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
    );

    typedef struct packed {
        logic        is_data;
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        logic        is_d;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be_in;
        int          lat;
        logic        exp_rd;
        logic        exp_wr;
        logic [3:0]  exp_be;
    } vec_t;

    grant_t      exp_q[$];
    logic [31:0] ifq[$];
    logic [31:0] dq[$];
    vec_t        vt[6];

    int n_vec = 0;
    int n_err = 0;
    int mem_lat = 0;
    int resp_cnt = 0;
    bit stray = 1'b0;
    logic strobe_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h60) ? 32'h00A00093 : {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_vec++;
        n_err++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic push_grant(input logic is_d, input logic rd, input logic wr,
                              input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
        exp_q.push_back({is_d, rd, wr, be, a, wd});
    endtask

    // Memory model: answers an active strobe after mem_lat cycles, one-cycle pulse.
    always begin
        @(posedge clk);
        #1;
        if (rst || bus.mem_resp) begin
            bus.mem_resp  = 1'b0;
            bus.mem_rdata = 32'($urandom);
            resp_cnt      = 0;
        end else if (bus.mem_read || bus.mem_write) begin
            if (resp_cnt >= mem_lat) begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = mem_word(bus.mem_address);
            end else begin
                resp_cnt++;
            end
        end else if (stray) begin
            bus.mem_resp = 1'b1;
            stray        = 1'b0;
        end else begin
            resp_cnt = 0;
        end
    end

    // Grant scoreboard: each new strobe must match the next predicted grant.
    always @(negedge clk) begin : grant_mon
        logic   act;
        grant_t g;
        act = bus.mem_read | bus.mem_write;
        if (act && !strobe_prev) begin
            if (exp_q.size() == 0) begin
                fail("grant_unexpected", $sformatf("got grant to %h, required none", bus.mem_address));
            end else begin
                g = exp_q.pop_front();
                check("grant_read", 64'(bus.mem_read), 64'(g.rd));
                check("grant_write", 64'(bus.mem_write), 64'(g.wr));
                check("grant_be", 64'(bus.mem_byte_enable), 64'(g.be));
                check("grant_addr", 64'(bus.mem_address), 64'(g.addr));
                if (g.is_data) check("grant_wdata", 64'(bus.mem_wdata), 64'(g.wdata));
            end
        end
        strobe_prev = act;
    end

    // Response scoreboard: every resp pulse pops the requester's expected data.
    always @(negedge clk) begin
        if (bus.i_resp && bus.d_resp) fail("both_resp", "got i_resp and d_resp together, required one");
        if (bus.i_resp) begin
            if (ifq.size() == 0) fail("i_resp_unexpected", "got i_resp=1, required 0");
            else check("i_rdata", 64'(bus.i_rdata), 64'(ifq.pop_front()));
        end
        if (bus.d_resp) begin
            if (dq.size() == 0) fail("d_resp_unexpected", "got d_resp=1, required 0");
            else check("d_rdata", 64'(bus.d_rdata), 64'(dq.pop_front()));
        end
    end

    // Called just after a rising edge; returns just after the edge that ends the response.
    task automatic do_req(input logic is_d, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input bit chk_lat, input bit keep);
        logic got;
        got = 1'b0;
        if (is_d) begin
            bus.d_read = rd;
            bus.d_write = wr;
            bus.d_addr = a;
            bus.d_wdata = wd;
            bus.d_byte_enable = be;
            dq.push_back(mem_word(a));
        end else begin
            bus.i_read = 1'b1;
            bus.i_addr = a;
            ifq.push_back(mem_word(a));
        end
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (chk_lat && t == 0) check("latency_pre", 64'(bus.mem_read | bus.mem_write), 64'(0));
            if (chk_lat && t == 1)
                check("latency_strobe", 64'({bus.mem_read | bus.mem_write, bus.mem_address}), 64'({1'b1, a}));
            got = is_d ? bus.d_resp : bus.i_resp;
        end
        if (!got) fail("resp_timeout", $sformatf("got no resp for %h, required one", a));
        @(posedge clk);
        #1;
        if (!keep) begin
            if (is_d) begin
                bus.d_read = 1'b0;
                bus.d_write = 1'b0;
            end else begin
                bus.i_read = 1'b0;
            end
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, "_state"}, 64'(state_o), 64'(0));
        check({name, "_strobes"}, 64'({bus.mem_read, bus.mem_write}), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.i_read = 1'b0;
        bus.i_addr = '0;
        bus.d_read = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        bus.d_byte_enable = '0;
        bus.mem_resp = 1'b0;
        bus.mem_rdata = '0;

        vt[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0060, 32'h0, 4'h0, 3, 1'b1, 1'b0, 4'h0};
        vt[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_1004, 32'h1111_2222, 4'h5, 0, 1'b1, 1'b0, 4'hF};
        vt[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_1008, 32'h1234_5678, 4'hC, 1, 1'b0, 1'b1, 4'hC};
        vt[3] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 2, 1'b1, 1'b0, 4'h0};
        vt[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_2004, 32'hCAFE_F00D, 4'h1, 1, 1'b0, 1'b1, 4'h1};
        vt[5] = '{1'b1, 1'b0, 1'b1, 32'h0000_100C, 32'hA5A5_A5A5, 4'h0, 5, 1'b0, 1'b1, 4'h0};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 64'(state_o), 64'(0));
        check("rst_mem_read", 64'(bus.mem_read), 64'(0));
        check("rst_mem_write", 64'(bus.mem_write), 64'(0));
        check("rst_mem_address", 64'(bus.mem_address), 64'(0));
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
        check("rst_mem_be", 64'(bus.mem_byte_enable), 64'(0));
        check("rst_resps", 64'({bus.i_resp, bus.d_resp}), 64'(0));
        check("rst_rdata", 64'({bus.i_rdata, bus.d_rdata}), 64'(0));
        rst = 1'b0;

        // Single-requester vectors
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            mem_lat = vt[k].lat;
            push_grant(vt[k].is_d, vt[k].exp_rd, vt[k].exp_wr, vt[k].exp_be, vt[k].addr, vt[k].wdata);
            do_req(vt[k].is_d, vt[k].rd, vt[k].wr, vt[k].addr, vt[k].wdata, vt[k].be_in, 1'b1, 1'b0);
            @(negedge clk);
            check_quiet("vec_idle_after");
        end

        // Simultaneous fetch and store: store first, then the fetch
        @(posedge clk);
        #1;
        mem_lat = 1;
        push_grant(1'b1, 1'b0, 1'b1, 4'h3, 32'h1000, 32'hDEAD_BEEF);
        push_grant(1'b0, 1'b1, 1'b0, 4'h0, 32'h64, 32'h0);
        fork
            do_req(1'b1, 1'b0, 1'b1, 32'h1000, 32'hDEAD_BEEF, 4'h3, 1'b1, 1'b0);
            do_req(1'b0, 1'b1, 1'b0, 32'h64, 32'h0, 4'h0, 1'b0, 1'b0);
        join

        // Continuous load stream while a fetch waits
        @(posedge clk);
        #1;
        mem_lat = 0;
        for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (k == 4) push_grant(1'b0, 1'b1, 1'b0, 4'h0, 32'h300, 32'h0);
`endif
            push_grant(1'b1, 1'b1, 1'b0, 4'hF, 32'h4000 + 32'(4 * k), 32'h0);
        end
`ifndef MEM_ARB_STARVE_GUARD_EN
        push_grant(1'b0, 1'b1, 1'b0, 4'h0, 32'h300, 32'h0);
`endif
        fork
            do_req(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0, 1'b0);
            begin
                for (int k = 0; k < 6; k++)
                    do_req(1'b1, 1'b1, 1'b0, 32'h4000 + 32'(4 * k), 32'h0, 4'hF, 1'b0, k < 5);
            end
        join
        @(negedge clk);
        check_quiet("starve_idle_after");

        // Flush one cycle before mem_resp: strobe held, no i_resp
        @(posedge clk);
        #1;
        mem_lat = 3;
        push_grant(1'b0, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0);
        bus.i_read = 1'b1;
        bus.i_addr = 32'h80;
        begin : wait_fetch
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (bus.mem_read) disable wait_fetch;
            end
            fail("flush_grant_timeout", "got no mem_read for 0x80, required one");
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        bus.i_read = 1'b0;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_drop_state", 64'(state_o), 64'(3));
        check("flush_drop_strobe", 64'(bus.mem_read), 64'(1));
        check("flush_drop_i_resp", 64'(bus.i_resp), 64'(0));
        @(negedge clk);
        check_quiet("flush_drop_after");
        @(posedge clk);
        #1;
        push_grant(1'b0, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0);
        do_req(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 1'b1, 1'b0);

        // Flush in the same cycle as mem_resp during a fetch
        @(posedge clk);
        #1;
        mem_lat = 0;
        push_grant(1'b0, 1'b1, 1'b0, 4'h0, 32'h90, 32'h0);
        bus.i_read = 1'b1;
        bus.i_addr = 32'h90;
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_resp_state", 64'(state_o), 64'(1));
        check("flush_resp_i_resp", 64'(bus.i_resp), 64'(0));
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.i_read = 1'b0;
        @(negedge clk);
        check_quiet("flush_resp_after");

        // Flush in IDLE blocks a fetch grant
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        bus.i_read = 1'b1;
        bus.i_addr = 32'hA0;
        @(negedge clk);
        @(negedge clk);
        check_quiet("flush_idle_block");
        @(posedge clk);
        #1;
        bus.i_read = 1'b0;

        // Load under a held flush completes normally
        mem_lat = 2;
        push_grant(1'b1, 1'b1, 1'b0, 4'hF, 32'h3004, 32'h0);
        do_req(1'b1, 1'b1, 1'b0, 32'h3004, 32'h0, 4'h7, 1'b1, 1'b0);
        bus.flush = 1'b0;

        // mem_resp in IDLE is ignored
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        check("stray_resp_state", 64'(state_o), 64'(0));
        check("stray_resp_outs", 64'({bus.i_resp, bus.d_resp, bus.mem_read, bus.mem_write}), 64'(0));
        @(negedge clk);
        check_quiet("stray_after");

        // Asynchronous reset in the middle of a store
        @(posedge clk);
        #1;
        mem_lat = 6;
        push_grant(1'b1, 1'b0, 1'b1, 4'hF, 32'h3000, 32'h0BAD_F00D);
        bus.d_write = 1'b1;
        bus.d_addr = 32'h3000;
        bus.d_wdata = 32'h0BAD_F00D;
        bus.d_byte_enable = 4'hF;
        begin : wait_store
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (bus.mem_write) disable wait_store;
            end
            fail("rst_grant_timeout", "got no mem_write for 0x3000, required one");
        end
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", 64'(state_o), 64'(0));
        check("arst_strobes", 64'({bus.mem_read, bus.mem_write}), 64'(0));
        check("arst_address", 64'(bus.mem_address), 64'(0));
        check("arst_wdata", 64'(bus.mem_wdata), 64'(0));
        check("arst_be", 64'(bus.mem_byte_enable), 64'(0));
        check("arst_resps", 64'({bus.i_resp, bus.d_resp}), 64'(0));
        bus.d_write = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        mem_lat = 1;
        push_grant(1'b1, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0BAD_F00D);
        do_req(1'b1, 1'b1, 1'b0, 32'h2000, 32'h0BAD_F00D, 4'h0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'(0));
        check("ifq_drained", 64'(ifq.size()), 64'(0));
        check("dq_drained", 64'(dq.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
